axi4_rd_burst_ctrl: RTL and testbench
=====================================

// Module: axi4_rd_burst_ctrl
// PURPOSE
//  AXI4 read-slave burst sequencer. Accepts one AR request at a time and expands it into per-beat
//  word reads on a simple synchronous memory port. Supports FIXED, INCR and WRAP burst types.
//  Returns data on the R channel with RID/RLAST/RRESP and full backpressure at one beat per cycle.
//  Sits between the AXI4 interconnect and the register/buffer memories of the SPI controller.
// PARAMETERS
//  AW  32  byte address width
//  DW  32  data width in bits (8..1024, power of 2); BW=DW/8, WS=$clog2(BW)
//  IW   4  AXI ID width
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-high
//  axi_arvalid in 1      AR valid
//  axi_arready out 1     AR ready
//  axi_arid  in   IW     AR ID
//  axi_araddr in  AW     AR byte address
//  axi_arlen in   8      AR burst length (beats-1)
//  axi_arsize in  3      AR beat size, log2 bytes
//  axi_arburst in 2      AR burst type (FIXED/INCR/WRAP encoding)
//  axi_rvalid out 1      R valid
//  axi_rready in  1      R ready
//  axi_rid   out  IW     R ID (echo of ARID)
//  axi_rdata out  DW     R data
//  axi_rresp out  2      R response (OKAY/SLVERR)
//  axi_rlast out  1      R last beat
//  mem_ren   out  1      memory read enable
//  mem_adr   out  AW-WS  memory word address
//  mem_rdt   in   DW     memory read data, valid exactly 1 cycle after mem_ren
// BEHAVIOUR
//  Reset: arready=0 during rst then 1 in IDLE; rvalid=0, rlast=0, rresp=OKAY, rid=0, rdata=0, mem_ren=0, mem_adr=0; FSM=IDLE, FIFO empty.
//  FSM IDLE: arready=1; AR handshake latches id/addr/len/size/burst, beats=len+1 -> ISSUE.
//  FSM ISSUE: arready=0; issue one mem read per cycle when credit allows; after last issue -> DRAIN.
//  FSM DRAIN: wait until FIFO empty and no read in flight with final beat accepted -> IDLE (arready=1 next cycle).
//  Credit: 2-entry R FIFO; issue iff fifo_cnt + inflight - (rvalid&rready) < 2. Never drops/overwrites data.
//  Latency: AR handshake cycle T -> mem_ren at T+1 -> mem_rdt at T+2 -> rvalid at T+3.
//  Throughput: rready held 1 -> one beat per cycle, no bubbles, LEN+1 beats in LEN+1 consecutive cycles.
//  Addr gen (size=1<<arsize): FIXED a'=a; INCR a'=(a & ~(size-1))+size;
//   WRAP bound=size*(len+1), a'=(a & ~(bound-1)) | ((a+size) & (bound-1)). mem_adr=a[AW-1:WS].
//  INCR wraps modulo 2^AW; 4KB crossing not checked in base build.
//  rdata passes full DW word unmodified (narrow-lane selection is master's job); rresp=OKAY.
//  rlast=1 only with the beat numbered len; rid constant for whole burst.
//  rvalid stays high with stable payload until rready; rready without rvalid ignored.
//  len=0 -> single beat with rlast=1. New AR never accepted while a burst is in any stage.
//  Reset mid-burst: everything aborts immediately; remaining beats are never returned.
// CONFIGURATION
//  AXI4_RD_BURST_CHK_EN defined: AR checked at handshake; illegal if arsize>WS, or WRAP with len not
//   in {1,3,7,15}, or WRAP addr not size-aligned, or burst=2'b11. Illegal burst: no mem_ren,
//   len+1 beats returned, rresp=SLVERR, rdata=0, rlast on final beat, same credit/throughput rules.
//  Not defined: no checks, rresp always OKAY, illegal bursts still return exactly len+1 beats,
//   addresses per formula (content unspecified).
// TESTING
//  INCR len=3 size=2 addr=0x10 DW=32, rready=1 -> mem_adr 4,5,6,7; rvalid cycles T+3..T+6; rlast on 4th.
//  WRAP len=3 size=2 addr=0x38 -> byte addr 0x38,0x3C,0x30,0x34 (mem_adr 14,15,12,13).
//  FIXED len=2 addr=0x20 id=5 -> mem_adr 8 three times, rid=5 all beats, rlast on 3rd.
//  INCR len=7, rready pattern 1,0,0,1,0,1... -> 8 beats in order, payload stable while stalled, FIFO never exceeds 2.
//  rst pulse at 2nd beat of len=7 -> rvalid=0 and arready=1 after release; next AR burst correct.
//  CHK_EN: WRAP len=2 -> 3 beats rresp=SLVERR, rdata=0, no mem_ren; without macro -> 3 OKAY beats.

Source files
------------

// File: rtl/axi4_rd_burst_ctrl.sv
// AXI4 read-slave burst sequencer: expands one AR request into per-beat memory reads and streams R beats.
// Optional AXI4_RD_BURST_CHK_EN rejects illegal AR requests with SLVERR beats and no memory access.
module axi4_rd_burst_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axi_arvalid,
    output logic             axi_arready,
    input  logic [IW-1:0]    axi_arid,
    input  logic [AW-1:0]    axi_araddr,
    input  logic [7:0]       axi_arlen,
    input  logic [2:0]       axi_arsize,
    input  logic [1:0]       axi_arburst,
    output logic             axi_rvalid,
    input  logic             axi_rready,
    output logic [IW-1:0]    axi_rid,
    output logic [DW-1:0]    axi_rdata,
    output logic [1:0]       axi_rresp,
    output logic             axi_rlast,
    output logic             mem_ren,
    output logic [AW-$clog2(DW/8)-1:0] mem_adr,
    input  logic [DW-1:0]    mem_rdt
);
    localparam int WS = $clog2(DW/8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   id_q;
    logic [AW-1:0]   a_q, a_nxt;
    logic [7:0]      len_q, cnt_q;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic            err_q, ar_err;
    logic            infl_q, infl_last_q;
    logic [DW-1:0]   dat_q [2];
    logic            last_q [2];
    logic            wp_q, rp_q;
    logic [1:0]      fcnt_q;

    logic            ar_hs, pop, push, issue, last_issue, credit_ok, drained;
    logic [AW-1:0]   sz, bound;

    assign ar_hs       = axi_arvalid & axi_arready;
    assign push        = infl_q;
    assign pop         = axi_rvalid & axi_rready;
    assign axi_arready = (state_q == IDLE) & ~rst;
    assign axi_rvalid  = (fcnt_q != 2'd0);
    assign axi_rdata   = dat_q[rp_q];
    assign axi_rlast   = axi_rvalid & last_q[rp_q];
    assign axi_rresp   = err_q ? 2'b10 : 2'b00;
    assign axi_rid     = id_q;
    assign mem_adr     = a_q[AW-1:WS];

    // A read is issued only if its data is guaranteed a FIFO slot when it returns.
    assign credit_ok  = ({1'b0, fcnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2;
    assign issue      = (state_q == ISSUE) && credit_ok;
    assign last_issue = issue && (cnt_q == len_q);
    assign mem_ren    = issue & ~err_q;
    assign drained    = !infl_q && ((fcnt_q == 2'd0) || (fcnt_q == 2'd1 && pop));

`ifdef AXI4_RD_BURST_CHK_EN
    logic [AW-1:0] ar_sz;
    always_comb begin
        ar_sz  = AW'(1) << axi_arsize;
        ar_err = (int'(axi_arsize) > WS) || (axi_arburst == 2'b11) ||
                 ((axi_arburst == 2'b10) &&
                  (!(axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                   ((axi_araddr & (ar_sz - AW'(1))) != '0)));
    end
`else
    assign ar_err = 1'b0;
`endif

    always_comb begin
        sz    = AW'(1) << size_q;
        bound = sz * AW'({1'b0, len_q} + 9'd1);
        a_nxt = a_q;
        case (burst_q)
            2'b01:   a_nxt = (a_q & ~(sz - AW'(1))) + sz;
            2'b10:   a_nxt = (a_q & ~(bound - AW'(1))) | ((a_q + sz) & (bound - AW'(1)));
            default: a_nxt = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            a_q         <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            fcnt_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                dat_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            infl_q      <= issue;
            infl_last_q <= last_issue;
            if (ar_hs) begin
                id_q    <= axi_arid;
                a_q     <= axi_araddr;
                len_q   <= axi_arlen;
                size_q  <= axi_arsize;
                burst_q <= axi_arburst;
                err_q   <= ar_err;
                cnt_q   <= '0;
            end else if (issue) begin
                a_q     <= a_nxt;
                cnt_q   <= cnt_q + 8'd1;
            end
            // Rejected bursts still flow through the FIFO so beat timing matches legal ones.
            if (push) begin
                dat_q[wp_q]  <= err_q ? '0 : mem_rdt;
                last_q[wp_q] <= infl_last_q;
                wp_q         <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_axi4_rd_burst_ctrl.sv
// Scoreboard bench for axi4_rd_burst_ctrl: expected beats and memory addresses are queued at AR
// handshake from a byte-address model; monitors pop and compare on mem_ren and R handshakes.
module tb_axi4_rd_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [3:0]  axi_arid = '0;
    logic [31:0] axi_araddr = '0;
    logic [7:0]  axi_arlen = '0;
    logic [2:0]  axi_arsize = '0;
    logic [1:0]  axi_arburst = '0;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [3:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        mem_ren;
    logic [29:0] mem_adr;
    logic [31:0] mem_rdt = '0;

    axi4_rd_burst_ctrl #(.AW(32), .DW(32), .IW(4)) dut (
        .clk(clk), .rst(rst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .mem_ren(mem_ren), .mem_adr(mem_adr), .mem_rdt(mem_rdt)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        bit          dc;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] mem_q[$];
    int          acc_cyc[$];
    int          total = 0, bad = 0;
    int          cyc = 0, acc_count = 0, issued = 0, accepted = 0, max_out = 0;
    int          rr_mode = 0, pidx = 0;
    bit          ign_mem = 0;
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [29:0] w);
        return {~w[15:0], w[15:0]} ^ 32'h1234_0000;
    endfunction

    always @(posedge clk) if (mem_ren) mem_rdt <= memf(mem_adr);

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: axi_rready = 1'b1;
            1: axi_rready = ($urandom_range(0, 9) < 6);
            default: begin
                axi_rready = pat[pidx];
                pidx = (pidx == 5) ? 0 : pidx + 1;
            end
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Byte address of beat i, straight from the burst-type definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [2:0] sl,
                                              input logic [7:0] len, input logic [1:0] bt, input int i);
        logic [31:0] szb, bnd, base;
        szb = 32'd1 << sl;
        case (bt)
            2'b01: return (i == 0) ? s : (s & ~(szb - 1)) + 32'(i) * szb;
            2'b10: begin
                bnd  = szb * (32'(len) + 1);
                base = s - (s % bnd);
                return base + ((s - base + 32'(i) * szb) % bnd);
            end
            default: return s;
        endcase
    endfunction

    task automatic push_exp(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sl, input logic [1:0] bt, input bit ill);
        exp_t e;
        logic [31:0] ba;
        for (int i = 0; i <= int'(len); i++) begin
            ba     = beat_addr(a, sl, len, bt, i);
            e.id   = id;
            e.last = (i == int'(len));
            if (ill) begin
`ifdef AXI4_RD_BURST_CHK_EN
                e.resp = 2'b10; e.data = '0; e.dc = 0;
`else
                e.resp = 2'b00; e.data = '0; e.dc = 1;
`endif
            end else begin
                e.resp = 2'b00; e.data = memf(ba[31:2]); e.dc = 0;
                mem_q.push_back(ba[31:2]);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sl, input logic [1:0] bt, input bit ill, output int t);
        @(posedge clk); #1;
        axi_arvalid = 1'b1; axi_arid = id; axi_araddr = a;
        axi_arlen = len; axi_arsize = sl; axi_arburst = bt;
        t = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (axi_arready) begin t = cyc; break; end
        end
        if (t < 0) chk("ar_timeout", 1, 0);
        else begin
            chk("ar_only_when_idle", 64'(exp_q.size()), 0);
            issued = 0; accepted = 0;
            push_exp(id, a, len, sl, bt, ill);
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (k == 3000) chk("burst_timeout", 64'(exp_q.size()), 0);
    endtask

    // Monitor: memory-port addresses, R beats, payload stability under stall, outstanding depth.
    logic        hold_v = 0;
    logic [31:0] h_data;
    logic [3:0]  h_id;
    logic        h_last;
    logic [1:0]  h_resp;
    always @(negedge clk) begin
        if (rst) hold_v = 0;
        else begin
            if (mem_ren) begin
                issued++;
                if (!ign_mem) begin
                    if (mem_q.size() == 0) chk("unexpected_mem_ren", 1, 0);
                    else chk("mem_adr", 64'(mem_adr), 64'(mem_q.pop_front()));
                end
            end
            if (hold_v) begin
                chk("stall_rvalid", 64'(axi_rvalid), 1);
                chk("stall_payload", {axi_rid, axi_rresp, axi_rlast, axi_rdata},
                    {h_id, h_resp, h_last, h_data});
            end
            if (axi_rvalid && axi_rready) begin
                accepted++; acc_count++;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rid", 64'(axi_rid), 64'(e.id));
                    chk("rresp", 64'(axi_rresp), 64'(e.resp));
                    chk("rlast", 64'(axi_rlast), 64'(e.last));
                    if (!e.dc) chk("rdata", 64'(axi_rdata), 64'(e.data));
                end
            end
            hold_v = axi_rvalid && !axi_rready;
            h_data = axi_rdata; h_id = axi_rid; h_last = axi_rlast; h_resp = axi_rresp;
            if (issued - accepted > max_out) max_out = issued - accepted;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base;
        logic [7:0]  len;
        logic [2:0]  sl;
        logic [1:0]  bt;
        logic [31:0] a;
        logic [7:0]  wl [4] = '{8'd1, 8'd3, 8'd7, 8'd15};

        repeat (3) @(negedge clk);
        chk("rst_arready", 64'(axi_arready), 0);
        chk("rst_rvalid_rlast_ren", {axi_rvalid, axi_rlast, mem_ren}, 0);
        chk("rst_payload", {axi_rid, axi_rresp, axi_rdata}, 0);
        chk("rst_mem_adr", 64'(mem_adr), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_arready", 64'(axi_arready), 1);

        // INCR len=3 size=2 at 0x10: latency and back-to-back beats.
        rr_mode = 0;
        acc_cyc.delete();
        send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01, 0, t);
        wait_done();
        chk("incr_beats", 64'(acc_cyc.size()), 4);
        if (acc_cyc.size() >= 4) begin
            chk("incr_first_latency", 64'(acc_cyc[0] - t), 3);
            chk("incr_last_cycle", 64'(acc_cyc[3] - t), 6);
        end

        send_ar(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, 0, t);
        wait_done();
        send_ar(4'd5, 32'h20, 8'd2, 3'd2, 2'b00, 0, t);
        wait_done();

        rr_mode = 2; pidx = 0;
        send_ar(4'd3, 32'h100, 8'd7, 3'd2, 2'b01, 0, t);
        wait_done();
        rr_mode = 0;

        // Reset while beat 2 of an 8-beat burst is in flight.
        base = acc_count;
        send_ar(4'd6, 32'h200, 8'd7, 3'd2, 2'b01, 0, t);
        for (int k = 0; k < 100 && acc_count < base + 2; k++) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete(); mem_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", 64'(axi_rvalid), 0);
        chk("post_rst_arready", 64'(axi_arready), 1);
        send_ar(4'd7, 32'h300, 8'd1, 3'd2, 2'b01, 0, t);
        wait_done();

        // WRAP with len=2 is not a legal wrap length.
`ifndef AXI4_RD_BURST_CHK_EN
        ign_mem = 1;
`endif
        send_ar(4'd9, 32'h40, 8'd2, 3'd2, 2'b10, 1, t);
        wait_done();
        repeat (3) @(negedge clk);
        ign_mem = 0;

        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            bt = 2'($urandom_range(0, 2));
            sl = 3'($urandom_range(0, 2));
            if (bt == 2'b10) begin
                len = wl[$urandom_range(0, 3)];
                a   = $urandom & ~((32'd1 << sl) - 1);
            end else begin
                len = 8'($urandom_range(0, 15));
                a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            end
            send_ar(4'($urandom), a, len, sl, bt, 0, t);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_done();
        rr_mode = 0;
        repeat (5) @(negedge clk);
        chk("queues_empty", 64'(exp_q.size() + mem_q.size()), 0);
        chk("fifo_depth_max2", 64'(max_out > 2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
